// File: rtl/mmio_gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mmio_gpio_pkg                                             |
// | Purpose  : Register offsets and STATUS/CTRL bit positions shared by  |
// |            the MMIO GPIO responder and its testbench.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mmio_gpio_pkg;

  // Word offsets from BASE_ADDR
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_GPIN   = 2'd3;

  // Number of registers in the window
  localparam int unsigned NUM_REGS = 4;

  // STATUS bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_MSB = 4;
  localparam int ST_OVF     = 5;

  // CTRL bit positions
  localparam int CTRL_EN = 0;

endpackage : mmio_gpio_pkg
`default_nettype wire

// File: rtl/mmio_gpio_responder_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_fifo                                                 |
// | Purpose  : Single-clock FIFO with registered storage, occupancy      |
// |            count and a registered head output. A push into a full    |
// |            FIFO is accepted only when a pop happens in the same      |
// |            cycle.                                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  // Popping frees a slot at the same edge, so a full FIFO can still take a byte
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage write at the tail; contents cleared on reset so head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/mmio_gpio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mmio_gpio_responder                                       |
// | Purpose  : Memory-mapped responder beside the data memory. CPU byte  |
// |            stores are queued in a TX FIFO and drained to a GPIO      |
// |            consumer over valid/ready; an external 8-bit input is     |
// |            synchronized for CPU loads.                               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mmio_gpio_responder
  import mmio_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          DEPTH     = 4,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        wmem,
  input  logic        rmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic [7:0]  gpio_out,
  output logic        gpio_valid,
  input  logic        gpio_ready,
  input  logic [7:0]  gpio_in
);

  logic [31:0]      offset;
  logic [1:0]       reg_sel;
  logic             wr_data;
  logic             wr_status;
  logic             wr_ctrl;
  logic             en;
  logic             ovf;
  logic [7:0]       sync_1;
  logic [7:0]       sync_2;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [2:0]       cnt_field;
  logic             pop;
  logic             unused_bits;

  // Loads have no side effects and upper store bits are don't-care
  assign unused_bits = ^{rmem, wdata[31:8]};

  // Modular subtraction keeps the window test correct for any BASE_ADDR
  assign offset    = addr - BASE_ADDR;
  assign hit       = (offset < 32'(NUM_REGS));
  assign reg_sel   = offset[1:0];
  assign wr_data   = wmem & hit & (reg_sel == OFF_DATA);
  assign wr_status = wmem & hit & (reg_sel == OFF_STATUS);
  assign wr_ctrl   = wmem & hit & (reg_sel == OFF_CTRL);

  assign gpio_valid = en & ~fifo_empty;
  assign pop        = gpio_valid & gpio_ready;
  assign cnt_field  = 3'(fifo_cnt);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_data),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .cnt       (fifo_cnt),
    .head      (gpio_out)
  );

  // Drain enable and sticky overflow; a new overflow wins over a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (wr_ctrl) en <= wdata[CTRL_EN];
      if (wr_data && fifo_full && !pop) begin
        ovf <= 1'b1;
      end else if (wr_status && wdata[ST_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  // Two-stage synchronizer for the asynchronous GPIO input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= gpio_in;
      sync_2 <= sync_1;
    end
  end

  // Load data mux; zero outside the window and for write-only registers
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (reg_sel)
        OFF_STATUS: begin
          rdata[ST_FULL]                  = fifo_full;
          rdata[ST_EMPTY]                 = fifo_empty;
          rdata[ST_CNT_MSB:ST_CNT_LSB]    = cnt_field;
          rdata[ST_OVF]                   = ovf;
        end
        OFF_CTRL:   rdata[CTRL_EN] = en;
        OFF_GPIN:   rdata[7:0]     = sync_2;
        default:    rdata          = '0;
      endcase
    end
  end

endmodule : mmio_gpio_responder
`default_nettype wire

// File: tb/tb_mmio_gpio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mmio_gpio_responder                                    |
// | Purpose  : Self-checking bench with a queue-based reference model    |
// |            and directed plus randomized CPU/GPIO traffic.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_mmio_gpio_responder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wmem = 1'b0;
  logic        rmem = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  gpio_out;
  logic        gpio_valid;
  logic        gpio_ready = 1'b0;
  logic [7:0]  gpio_in = '0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_en;
  logic [7:0] gin_hist [2];   // [0] = sampled last edge, [1] = two edges ago

  // Values seen in the most recent cycle, for literal checks
  logic [31:0] last_rdata;
  logic        last_hit;
  logic        last_valid;
  logic [7:0]  last_out;

  mmio_gpio_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wmem       (wmem),
    .rmem       (rmem),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .hit        (hit),
    .gpio_out   (gpio_out),
    .gpio_valid (gpio_valid),
    .gpio_ready (gpio_ready),
    .gpio_in    (gpio_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] off;
    int          sz;
    logic [2:0]  c3;
    off = a - BASE;
    sz  = q.size();
    c3  = sz[2:0];
    if (off >= 4) return 32'h0;
    case (off)
      0: return 32'h0;
      1: return {26'b0, m_ovf, c3, (sz == 0), (sz == DEPTH)};
      2: return {31'b0, m_en};
      default: return {24'b0, gin_hist[1]};
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf       = 1'b0;
    m_en        = 1'b1;
    gin_hist[0] = '0;
    gin_hist[1] = '0;
  endtask

  // One bus cycle: drive inputs at the falling edge, compare, advance the model
  task automatic cycle(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic [7:0] gi);
    logic        m_valid;
    logic        pop;
    logic        push;
    logic [31:0] off;
    @(negedge clk);
    wmem = w; rmem = r; addr = a; wdata = d; gpio_ready = rdy; gpio_in = gi;
    #1;
    off     = a - BASE;
    m_valid = m_en && (q.size() > 0);
    check("hit", {31'b0, hit}, {31'b0, (off < 4)});
    check("rdata", rdata, model_rdata(a));
    check("gpio_valid", {31'b0, gpio_valid}, {31'b0, m_valid});
    if (m_valid) check("gpio_out", {24'b0, gpio_out}, {24'b0, q[0]});
    last_rdata = rdata; last_hit = hit; last_valid = gpio_valid; last_out = gpio_out;
    // Next state as the rules define it
    pop  = m_valid && rdy;
    push = w && (off == 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (w && off == 1 && d[5]) begin
      m_ovf = 1'b0;
    end
    if (w && off == 2) m_en = d[0];
    gin_hist[1] = gin_hist[0];
    gin_hist[0] = gi;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, rdy, gpio_in);
  endtask

  task automatic store(input logic [1:0] o, input logic [31:0] d, input logic rdy);
    cycle(1'b1, 1'b0, BASE + 32'(o), d, rdy, gpio_in);
  endtask

  task automatic load(input logic [1:0] o, input logic rdy);
    cycle(1'b0, 1'b1, BASE + 32'(o), 32'h0, rdy, gpio_in);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic async_reset();
    @(negedge clk);
    gpio_ready = 1'b0; wmem = 1'b0; rmem = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_valid", {31'b0, gpio_valid}, 32'h0);
    check("reset_out", {24'b0, gpio_out}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Reset state
    load(2'd1, 1'b0); check("lit_status_reset", last_rdata, 32'h0000_0002);
    load(2'd2, 1'b0); check("lit_ctrl_reset", last_rdata, 32'h0000_0001);

    // Reset mid-stream
    store(2'd0, 32'h11, 1'b0);
    store(2'd0, 32'h22, 1'b0);
    async_reset();
    load(2'd1, 1'b0); check("lit_status_after_rst", last_rdata, 32'h0000_0002);
    load(2'd2, 1'b0); check("lit_ctrl_after_rst", last_rdata, 32'h0000_0001);

    // Ordering with one-cycle latency
    store(2'd0, 32'hA1, 1'b1);
    store(2'd0, 32'hB2, 1'b1);
    check("lit_first_valid", {31'b0, last_valid}, 32'h1);
    check("lit_first_out", {24'b0, last_out}, 32'hA1);
    store(2'd0, 32'hC3, 1'b1);
    check("lit_second_out", {24'b0, last_out}, 32'hB2);
    idle(1'b1);
    check("lit_third_out", {24'b0, last_out}, 32'hC3);
    idle(1'b1);

    // Overflow: five stores into a four-entry FIFO
    for (int i = 0; i < 5; i++) store(2'd0, 32'h40 + i, 1'b0);
    load(2'd1, 1'b0); check("lit_status_full_ovf", last_rdata, 32'h0000_0031);
    store(2'd1, 32'h20, 1'b0);
    load(2'd1, 1'b0); check("lit_status_full", last_rdata, 32'h0000_0011);

    // Full with simultaneous push and pop
    store(2'd0, 32'h5A, 1'b1);
    load(2'd1, 1'b0); check("lit_status_pushpop", last_rdata, 32'h0000_0011);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Drain enable
    store(2'd0, 32'h71, 1'b0);
    store(2'd0, 32'h72, 1'b0);
    store(2'd2, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("lit_disabled_valid", {31'b0, last_valid}, 32'h0);
    load(2'd1, 1'b1); check("lit_status_hold", last_rdata, 32'h0000_0008);
    store(2'd2, 32'h1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    store(2'd1, 32'h20, 1'b0);
    load(2'd1, 1'b0); check("lit_status_clean", last_rdata, 32'h0000_0002);

    // Synchronizer latency and out-of-window store
    cycle(1'b0, 1'b1, BASE + 32'd3, 32'h0, 1'b0, 8'h3C);
    load(2'd3, 1'b0);
    load(2'd3, 1'b0); check("lit_gpin", last_rdata, 32'h0000_003C);
    cycle(1'b1, 1'b0, BASE + 32'd4, 32'hEE, 1'b0, 8'h3C);
    check("lit_oow_hit", {31'b0, last_hit}, 32'h0);
    check("lit_oow_rdata", last_rdata, 32'h0);
    load(2'd1, 1'b0); check("lit_oow_status", last_rdata, 32'h0000_0002);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      logic        r;
      logic [7:0]  gi;
      int          sel;
      if ($urandom_range(0, 599) == 0) async_reset();
      sel = $urandom_range(0, 9);
      if (sel < 8) a = BASE + $urandom_range(0, 4);
      else if (sel == 8) a = BASE - 32'd1;
      else a = $urandom;
      w = ($urandom_range(0, 2) == 0);
      r = ~w & $urandom_range(0, 1);
      d = $urandom;
      // Keep drain mostly enabled so the FIFO keeps moving
      if (w && a == BASE + 32'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      gi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : gpio_in;
      cycle(w, r, a, d, $urandom_range(0, 2) != 0, gi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_mmio_gpio_responder
`default_nettype wire
